gesture_av_ctrl: RTL and testbench

- Central command controller for the gesture AV display path.
- Two requesters issue commands:
  - the debounced up/down push buttons, with auto-repeat;
  - the gesture sensor event stream, via a valid/ready handshake.
- Arbitrates between them, applies one command per cycle to held volume/frequency/mute state, and drives the existing volume LED and frequency segment displays.

---
 rtl/gesture_av_pkg.sv | 26 ++
 rtl/gesture_av_ctrl_button_debounce.sv | 89 ++++++++
 rtl/gesture_av_ctrl.sv | 160 ++++++++++++++++
 tb/tb_gesture_av_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_av_pkg.sv
// Shared types and constants for the gesture AV command controller.
//   gesture_cmd_t : 3-bit command code used by both the gesture stream and
//                   the button path (6 and 7 are reserved).
//   grant_t       : identifies which requester was granted most recently.
//   VOL_MAX       : highest stored volume value.
//   FREQ_MAX      : highest frequency setting.
package gesture_av_pkg;

  typedef enum logic [2:0] {
    CMD_NONE        = 3'd0,
    CMD_VOL_UP      = 3'd1,
    CMD_VOL_DOWN    = 3'd2,
    CMD_FREQ_UP     = 3'd3,
    CMD_FREQ_DOWN   = 3'd4,
    CMD_MUTE_TOGGLE = 3'd5
  } gesture_cmd_t;

  typedef enum logic {
    BUTTON  = 1'b0,
    GESTURE = 1'b1
  } grant_t;

  localparam logic [2:0] VOL_MAX  = 3'd7;
  localparam logic [7:0] FREQ_MAX = 8'd255;

endpackage

// File: rtl/gesture_av_ctrl_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce counter and
// auto-repeat timer for one active-low button.
// Ports:
//   Clock, nReset : system clock, asynchronous active-low reset
//   nButton_i     : raw active-low button, asynchronous to Clock
//   pressed_o     : debounced level, 1 while the button is held
//   pulse_o       : one-cycle pulse on the press edge and on each repeat
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic Clock,
  input  logic nReset,
  input  logic nButton_i,
  output logic pressed_o,
  output logic pulse_o
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    pulse_d = 1'b0;

    // The synchronised level must differ from the accepted level for
    // DEBOUNCE_CYCLES consecutive cycles before it is taken.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Repeat timer counts down from the press edge; a pulse fires when it
    // expires, after which it reloads with the repeat period.
    if (level_d && !level_q) begin
      pulse_d = 1'b1;
      rep_d   = DELAY_LOAD;
    end else if (level_d && level_q) begin
      if (rep_q == '0) begin
        pulse_d = 1'b1;
        rep_d   = PERIOD_LOAD;
      end else begin
        rep_d = rep_q - 1'b1;
      end
    end else begin
      rep_d = '0;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rep_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= !nButton_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      pulse_q <= pulse_d;
    end
  end

  assign pressed_o = level_q;
  assign pulse_o   = pulse_q;

endmodule

// File: rtl/gesture_av_ctrl.sv
// Central command controller for the gesture AV display path.
// Arbitrates round-robin between the button path (volume up/down with
// auto-repeat) and the gesture valid/ready stream, applies one command per
// cycle to the held volume/frequency/mute state.
// Ports:
//   Clock, nReset           : system clock, asynchronous active-low reset
//   nButtonUp, nButtonDown  : raw active-low volume buttons
//   gest_valid, gest_code   : gesture command stream (gesture_cmd_t codes)
//   gest_ready              : gesture accepted this cycle when valid
//   volume                  : effective volume, 0 while muted
//   frequency               : frequency setting for the segment display
//   muted                   : mute state
module gesture_av_ctrl
  import gesture_av_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int FREQ_RESET      = 128,
  parameter int VOL_RESET       = 3
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       nButtonUp,
  input  logic       nButtonDown,
  input  logic       gest_valid,
  input  logic [2:0] gest_code,
  output logic       gest_ready,
  output logic [2:0] volume,
  output logic [7:0] frequency,
  output logic       muted
);

  logic up_pulse, up_pressed;
  logic down_pulse, down_pressed;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_btn_up (
    .Clock    (Clock),
    .nReset   (nReset),
    .nButton_i(nButtonUp),
    .pressed_o(up_pressed),
    .pulse_o  (up_pulse)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_btn_down (
    .Clock    (Clock),
    .nReset   (nReset),
    .nButton_i(nButtonDown),
    .pressed_o(down_pressed),
    .pulse_o  (down_pulse)
  );

  // Held state
  logic         ready_en_q;
  logic         btn_pending_q, btn_pending_d;
  gesture_cmd_t btn_cmd_q, btn_cmd_d;
  grant_t       last_grant_q, last_grant_d;
  logic [2:0]   vol_q, vol_d;
  logic [7:0]   freq_q, freq_d;
  logic         muted_q, muted_d;

  logic         new_btn_valid;
  gesture_cmd_t new_btn_cmd;
  logic         gest_fire, btn_grant;
  gesture_cmd_t apply_cmd;

  // Up wins over down; down presses and repeats are dropped while up is held.
  assign new_btn_valid = up_pulse || (down_pulse && down_pressed && !up_pressed);
  assign new_btn_cmd   = up_pulse ? CMD_VOL_UP : CMD_VOL_DOWN;

  // ready_en_q keeps gest_ready low while in reset and for the first edge
  // after release; ready never depends on gest_valid.
  assign gest_ready = ready_en_q && (!btn_pending_q || (last_grant_q == BUTTON));
  assign gest_fire  = gest_valid && gest_ready;
  assign btn_grant  = btn_pending_q && !gest_fire;

  // Arbitration and pending-button register
  always_comb begin
    btn_pending_d = btn_pending_q;
    btn_cmd_d     = btn_cmd_q;
    last_grant_d  = last_grant_q;
    apply_cmd     = CMD_NONE;

    if (gest_fire) begin
      apply_cmd    = gesture_cmd_t'(gest_code);
      last_grant_d = GESTURE;
    end else if (btn_grant) begin
      apply_cmd     = btn_cmd_q;
      last_grant_d  = BUTTON;
      btn_pending_d = 1'b0;
    end

    // A fresh button event always lands in the pending slot, replacing an
    // older one or following one granted this cycle.
    if (new_btn_valid) begin
      btn_pending_d = 1'b1;
      btn_cmd_d     = new_btn_cmd;
    end
  end

  // Apply stage
  always_comb begin
    vol_d   = vol_q;
    freq_d  = freq_q;
    muted_d = muted_q;
    case (apply_cmd)
      CMD_VOL_UP: begin
        muted_d = 1'b0;
        if (vol_q != VOL_MAX) vol_d = vol_q + 3'd1;
      end
      CMD_VOL_DOWN: begin
        if (vol_q != 3'd0) vol_d = vol_q - 3'd1;
      end
      CMD_FREQ_UP: begin
        if (freq_q != FREQ_MAX) freq_d = freq_q + 8'd1;
      end
      CMD_FREQ_DOWN: begin
        if (freq_q != 8'd0) freq_d = freq_q - 8'd1;
      end
      CMD_MUTE_TOGGLE: begin
        muted_d = !muted_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ready_en_q    <= 1'b0;
      btn_pending_q <= 1'b0;
      btn_cmd_q     <= CMD_NONE;
      last_grant_q  <= GESTURE;
      vol_q         <= 3'(VOL_RESET);
      freq_q        <= 8'(FREQ_RESET);
      muted_q       <= 1'b0;
    end else begin
      ready_en_q    <= 1'b1;
      btn_pending_q <= btn_pending_d;
      btn_cmd_q     <= btn_cmd_d;
      last_grant_q  <= last_grant_d;
      vol_q         <= vol_d;
      freq_q        <= freq_d;
      muted_q       <= muted_d;
    end
  end

  assign volume    = muted_q ? 3'd0 : vol_q;
  assign frequency = freq_q;
  assign muted     = muted_q;

endmodule

// File: tb/tb_gesture_av_ctrl.sv
module tb_gesture_av_ctrl;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic       nButtonUp = 1'b1;
  logic       nButtonDown = 1'b1;
  logic       gest_valid = 1'b0;
  logic [2:0] gest_code = 3'd0;
  logic       gest_ready;
  logic [2:0] volume;
  logic [7:0] frequency;
  logic       muted;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural reference: stored volume, mute flag, frequency
  int m_vol;
  int m_freq;
  bit m_mute;

  gesture_av_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .FREQ_RESET     (128),
    .VOL_RESET      (3)
  ) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .nButtonUp  (nButtonUp),
    .nButtonDown(nButtonDown),
    .gest_valid (gest_valid),
    .gest_code  (gest_code),
    .gest_ready (gest_ready),
    .volume     (volume),
    .frequency  (frequency),
    .muted      (muted)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic model_reset();
    m_vol  = 3;
    m_freq = 128;
    m_mute = 1'b0;
  endtask

  task automatic model_apply(input int c);
    case (c)
      1: begin m_mute = 1'b0; m_vol = (m_vol < 7) ? m_vol + 1 : 7; end
      2: m_vol = (m_vol > 0) ? m_vol - 1 : 0;
      3: m_freq = (m_freq < 255) ? m_freq + 1 : 255;
      4: m_freq = (m_freq > 0) ? m_freq - 1 : 0;
      5: m_mute = !m_mute;
      default: ;
    endcase
  endtask

  task automatic apply_reset();
    nButtonUp   = 1'b1;
    nButtonDown = 1'b1;
    gest_valid  = 1'b0;
    gest_code   = 3'd0;
    nReset      = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (volume !== 3'd3) begin n_fail++; $display("FAIL reset_volume: got %0d required 3", volume); end
    n_cmp++; if (frequency !== 8'd128) begin n_fail++; $display("FAIL reset_freq: got %0d required 128", frequency); end
    n_cmp++; if (muted !== 1'b0) begin n_fail++; $display("FAIL reset_muted: got %0b required 0", muted); end
    n_cmp++; if (gest_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b required 0", gest_ready); end
    nReset = 1'b1;
    repeat (5) tick();
    n_cmp++; if (gest_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %0b required 1", gest_ready); end
    n_cmp++; if (volume !== 3'd3) begin n_fail++; $display("FAIL idle_volume: got %0d required 3", volume); end
    n_cmp++; if (frequency !== 8'd128) begin n_fail++; $display("FAIL idle_freq: got %0d required 128", frequency); end
    $display("test_reset done: volume=%0d frequency=%0d muted=%0b", volume, frequency, muted);
  endtask

  task automatic test_freq_sweep();
    apply_reset();
    gest_valid = 1'b1;
    gest_code  = 3'd3;
    for (int i = 0; i < 130; i++) begin
      tick();
      model_apply(3);
      n_cmp++;
      if (frequency !== 8'(m_freq)) begin
        n_fail++; $display("FAIL freq_up[%0d]: got %0d required %0d", i, frequency, m_freq);
      end
    end
    $display("test_freq_sweep up: frequency=%0d", frequency);
    gest_code = 3'd4;
    for (int i = 0; i < 300; i++) begin
      tick();
      model_apply(4);
      n_cmp++;
      if (frequency !== 8'(m_freq)) begin
        n_fail++; $display("FAIL freq_down[%0d]: got %0d required %0d", i, frequency, m_freq);
      end
    end
    gest_valid = 1'b0;
    n_cmp++; if (frequency !== 8'd0) begin n_fail++; $display("FAIL freq_floor: got %0d required 0", frequency); end
    $display("test_freq_sweep down: frequency=%0d", frequency);
  endtask

  task automatic test_random_gesture();
    logic [2:0] exp_v;
    int c;
    bit v;
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = $urandom_range(0, 7);
      gest_valid = v;
      gest_code  = 3'(c);
      n_cmp++;
      if (gest_ready !== 1'b1) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %0b required 1", i, gest_ready);
      end
      tick();
      if (v) model_apply(c);
      exp_v = m_mute ? 3'd0 : 3'(m_vol);
      n_cmp++;
      if (volume !== exp_v || frequency !== 8'(m_freq) || muted !== m_mute) begin
        n_fail++;
        $display("FAIL rand_state[%0d] code=%0d valid=%0b: got vol=%0d freq=%0d muted=%0b required vol=%0d freq=%0d muted=%0b",
                 i, c, v, volume, frequency, muted, exp_v, m_freq, m_mute);
      end
    end
    gest_valid = 1'b0;
    $display("test_random_gesture done: volume=%0d frequency=%0d muted=%0b", volume, frequency, muted);
  endtask

  task automatic test_button_repeat();
    int t0;
    int rel;
    logic [2:0] exp_v;
    apply_reset();
    // Short glitch shorter than the debounce window
    nButtonUp = 1'b0;
    tick();
    tick();
    nButtonUp = 1'b1;
    repeat (15) tick();
    n_cmp++; if (volume !== 3'd3) begin n_fail++; $display("FAIL glitch_volume: got %0d required 3", volume); end
    $display("button glitch: volume=%0d", volume);

    // Held press: step at press, then +20, +28, +36
    t0 = -1;
    nButtonUp = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 40) nButtonUp = 1'b1;
      if (t0 < 0) begin
        if (volume !== 3'd3) begin
          t0 = k;
          n_cmp++;
          if (volume !== 3'd4) begin n_fail++; $display("FAIL press_volume: got %0d required 4", volume); end
        end
      end else begin
        rel = k - t0;
        exp_v = (rel < 20) ? 3'd4 : (rel < 28) ? 3'd5 : (rel < 36) ? 3'd6 : 3'd7;
        n_cmp++;
        if (volume !== exp_v) begin
          n_fail++; $display("FAIL repeat_volume[+%0d]: got %0d required %0d", rel, volume, exp_v);
        end
      end
    end
    n_cmp++;
    if (t0 < 0 || t0 > 16) begin
      n_fail++; $display("FAIL press_latency: got %0d cycles required 1..16", t0);
    end
    repeat (20) tick();
    n_cmp++; if (volume !== 3'd7) begin n_fail++; $display("FAIL repeat_saturate: got %0d required 7", volume); end
    $display("button hold: first step at cycle %0d, final volume=%0d", t0, volume);

    // Both buttons together: only up is honoured
    apply_reset();
    nButtonUp   = 1'b0;
    nButtonDown = 1'b0;
    repeat (10) tick();
    nButtonUp   = 1'b1;
    nButtonDown = 1'b1;
    repeat (15) tick();
    n_cmp++; if (volume !== 3'd4) begin n_fail++; $display("FAIL both_buttons: got %0d required 4", volume); end
    // Down alone
    nButtonDown = 1'b0;
    repeat (10) tick();
    nButtonDown = 1'b1;
    repeat (15) tick();
    n_cmp++; if (volume !== 3'd3) begin n_fail++; $display("FAIL down_button: got %0d required 3", volume); end
    $display("button precedence: volume=%0d", volume);
  endtask

  task automatic test_back_to_back();
    bit rdy;
    int low_cnt;
    logic [2:0] exp_v;
    apply_reset();
    gest_valid = 1'b1;
    gest_code  = 3'd3;
    for (int p = 0; p < 2; p++) begin
      low_cnt = 0;
      nButtonUp = 1'b0;
      for (int k = 1; k <= 30; k++) begin
        rdy = gest_ready;
        tick();
        if (k == 10) nButtonUp = 1'b1;
        // A held gesture goes through whenever ready; otherwise the button wins.
        if (rdy) model_apply(3);
        else begin low_cnt++; model_apply(1); end
        exp_v = m_mute ? 3'd0 : 3'(m_vol);
        n_cmp++;
        if (volume !== exp_v || frequency !== 8'(m_freq)) begin
          n_fail++;
          $display("FAIL contention[%0d.%0d]: got vol=%0d freq=%0d required vol=%0d freq=%0d",
                   p, k, volume, frequency, exp_v, m_freq);
        end
      end
      n_cmp++;
      if (low_cnt != 1) begin
        n_fail++; $display("FAIL ready_low_cycles[%0d]: got %0d required 1", p, low_cnt);
      end
      $display("back_to_back press %0d: ready-low cycles=%0d volume=%0d frequency=%0d", p, low_cnt, volume, frequency);
    end
    gest_valid = 1'b0;
  endtask

  task automatic test_mute();
    int codes[9]  = '{1, 1, 5, 1, 5, 5, 5, 2, 5};
    int exp_v[9]  = '{4, 5, 0, 6, 0, 6, 0, 0, 5};
    int exp_m[9]  = '{0, 0, 1, 0, 1, 0, 1, 1, 0};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      gest_valid = 1'b1;
      gest_code  = 3'(codes[i]);
      tick();
      n_cmp++;
      if (volume !== 3'(exp_v[i]) || muted !== 1'(exp_m[i])) begin
        n_fail++;
        $display("FAIL mute_step[%0d] code=%0d: got vol=%0d muted=%0b required vol=%0d muted=%0d",
                 i, codes[i], volume, muted, exp_v[i], exp_m[i]);
      end
      $display("mute step %0d code=%0d: volume=%0d muted=%0b", i, codes[i], volume, muted);
    end
    gest_valid = 1'b0;
  endtask

  task automatic test_reset_midop();
    int codes[3] = '{1, 3, 5};
    bit seen;
    apply_reset();
    // vol 4, freq 129, muted; last grant is the gesture side
    for (int i = 0; i < 3; i++) begin
      gest_valid = 1'b1;
      gest_code  = 3'(codes[i]);
      tick();
    end
    gest_valid = 1'b0;
    nButtonUp  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (gest_ready === 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL midop_pending: got ready=1 for 20 cycles required a ready-low cycle"); end
    // Gesture now held unready with the button pending; hit reset before the edge.
    gest_valid = 1'b1;
    gest_code  = 3'd3;
    nButtonUp  = 1'b1;
    nReset     = 1'b0;
    #1;
    n_cmp++;
    if (volume !== 3'd3 || frequency !== 8'd128 || muted !== 1'b0 || gest_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got vol=%0d freq=%0d muted=%0b ready=%0b required vol=3 freq=128 muted=0 ready=0",
               volume, frequency, muted, gest_ready);
    end
    tick();
    tick();
    gest_valid = 1'b0;
    nReset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      n_cmp++;
      if (volume !== 3'd3 || frequency !== 8'd128 || muted !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_after[%0d]: got vol=%0d freq=%0d muted=%0b required vol=3 freq=128 muted=0",
                 k, volume, frequency, muted);
      end
    end
    $display("reset mid-operation: volume=%0d frequency=%0d muted=%0b", volume, frequency, muted);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_freq_sweep();
    test_random_gesture();
    test_button_repeat();
    test_back_to_back();
    test_mute();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
